// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller
// Purpose  : Instruction-fetch sequencer for a word-addressed program ROM with
//            a combinational read port. Owns the fetch PC and drives the ROM
//            address. Fetched words go into a 2-entry FIFO, which is presented
//            to decode through a valid/ready handshake. Redirects and
//            out-of-range or misaligned fetch faults are handled here.
// Ports    : clk, reset               - clock, synchronous active-high reset
//            enable_i                 - run enable (buffered entries still drain)
//            redirect_i/redirect_pc_i - restart fetch at a new byte address
//            id_ready_i               - decode accepts the head entry
//            mem_addr_o/mem_instr_i   - ROM address / same-cycle ROM data
//            instr_valid_o, instr_o, pc_o, pc_plus4_o - FIFO head towards decode
//            fault_o                  - fetch fault sticky until redirect
// Revision : 1.0 - initial release
// ============================================================================
module fetch_controller #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
  parameter int                    MEMORY_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  id_ready_i,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_instr_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  fault_o
);

  // First byte address past the end of the ROM window.
  localparam logic [DATA_WIDTH-1:0] c_fetch_limit = RESET_PC + DATA_WIDTH'(4 * MEMORY_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic [1:0]            r_count;
  logic                  r_head;
  logic [DATA_WIDTH-1:0] r_pc_mem    [2];
  logic [DATA_WIDTH-1:0] r_instr_mem [2];

  logic w_valid;
  logic w_pop;
  logic w_bad;
  logic w_push;
  logic w_tail;

  assign w_valid = (r_count != 2'd0);
  assign w_pop   = w_valid & id_ready_i;
  assign w_bad   = (r_fetch_pc[1:0] != 2'b00)
                 | (r_fetch_pc < RESET_PC)
                 | (r_fetch_pc >= c_fetch_limit);
  // A full FIFO may still accept a word when the head leaves in the same cycle.
  assign w_push  = (r_state == S_FETCH) & enable_i & ~redirect_i & ~w_bad
                 & ((r_count != 2'd2) | w_pop);
  // Tail slot is head + count (mod 2); at count 2 it is the slot being popped.
  assign w_tail  = r_head ^ r_count[0];

  // Control state, fetch PC and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
    end else if (redirect_i) begin
      // Flush everything, including an entry decode is accepting right now.
      r_state    <= S_FETCH;
      r_fetch_pc <= redirect_pc_i;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      case (r_state)
        S_IDLE: begin
          if (enable_i) begin
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          // The faulting address stays in r_fetch_pc for inspection.
          if (enable_i && w_bad) begin
            r_state <= S_FAULT;
          end
        end
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_pc_mem[w_tail]    <= r_fetch_pc;
      r_instr_mem[w_tail] <= mem_instr_i;
    end
  end

  assign mem_addr_o    = r_fetch_pc;
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? r_instr_mem[r_head] : '0;
  assign pc_o          = w_valid ? r_pc_mem[r_head] : '0;
  assign pc_plus4_o    = w_valid ? (r_pc_mem[r_head] + DATA_WIDTH'(4)) : '0;
  assign fault_o       = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_controller
// Purpose  : Self-checking bench for fetch_controller. A queue-based model of
//            the fetch buffer predicts every output each cycle; directed
//            scenarios add literal expectations at key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

  localparam logic [31:0] c_base  = 32'h0040_0000;
  localparam logic [31:0] c_limit = 32'h0040_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + ((a - c_base) >> 2);
  endfunction

  assign mem_instr = rom_word(mem_addr);

  fetch_controller #(
    .DATA_WIDTH  (32),
    .RESET_PC    (32'h0040_0000),
    .MEMORY_DEPTH(64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_i     (enable),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .id_ready_i   (id_ready),
    .mem_addr_o   (mem_addr),
    .mem_instr_i  (mem_instr),
    .instr_valid_o(instr_valid),
    .instr_o      (instr),
    .pc_o         (pc),
    .pc_plus4_o   (pc_plus4),
    .fault_o      (fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  int          m_phase;   // 0: waiting for enable, 1: fetching, 2: faulted

  always @(posedge clk) begin
    bit m_pop, m_push, m_bad;
    if (reset) begin
      m_q.delete();
      m_pc    = c_base;
      m_phase = 0;
    end else if (redirect) begin
      m_q.delete();
      m_pc    = redirect_pc;
      m_phase = 1;
    end else begin
      m_bad  = (m_pc[1:0] != 2'b00) || (m_pc < c_base) || (m_pc >= c_limit);
      m_pop  = (m_q.size() > 0) && id_ready;
      m_push = (m_phase == 1) && enable && !m_bad && ((m_q.size() < 2) || m_pop);
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        m_q.push_back('{pc: m_pc, instr: rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      if (m_phase == 0 && enable) m_phase = 1;
      else if (m_phase == 1 && enable && m_bad) m_phase = 2;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit          e_valid;
      logic [31:0] e_pc, e_instr;
      e_valid = (m_q.size() > 0);
      e_pc    = e_valid ? m_q[0].pc : 32'h0;
      e_instr = e_valid ? m_q[0].instr : 32'h0;
      chk("model_valid", {31'b0, instr_valid}, {31'b0, e_valid});
      chk("model_pc", pc, e_pc);
      chk("model_instr", instr, e_instr);
      chk("model_pc4", pc_plus4, e_valid ? e_pc + 32'd4 : 32'h0);
      chk("model_fault", {31'b0, fault}, (m_phase == 2) ? 32'd1 : 32'd0);
      chk("model_addr", mem_addr, m_pc);
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] last_pc;
    reset = 1'b1; enable = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    cyc(2);
    chk_en = 1'b1;
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", mem_addr, 32'h0040_0000);
    chk("rst_fault", {31'b0, fault}, 32'd0);

    // Stream start: valid two edges after reset release.
    reset = 1'b0; enable = 1'b1; id_ready = 1'b1;
    cyc(1);
    chk("start_not_yet", {31'b0, instr_valid}, 32'd0);
    cyc(1);
    chk("first_valid", {31'b0, instr_valid}, 32'd1);
    chk("first_pc", pc, 32'h0040_0000);
    chk("first_instr", instr, 32'h1000_0000);

    // Decode stall: buffer fills, fetch PC stalls.
    id_ready = 1'b0;
    cyc(5);
    chk("stall_head", pc, 32'h0040_0000);
    chk("stall_addr", mem_addr, 32'h0040_0008);
    id_ready = 1'b1;
    cyc(1);
    chk("resume_pc1", pc, 32'h0040_0004);
    cyc(1);
    chk("resume_pc2", pc, 32'h0040_0008);
    chk("resume_pc4", pc_plus4, 32'h0040_000C);

    // Redirect while full.
    id_ready = 1'b0;
    cyc(2);
    redirect = 1'b1; redirect_pc = 32'h0040_0040; id_ready = 1'b1;
    cyc(1);
    redirect = 1'b0;
    chk("redir_flush", {31'b0, instr_valid}, 32'd0);
    chk("redir_addr", mem_addr, 32'h0040_0040);
    cyc(1);
    chk("redir_pc", pc, 32'h0040_0040);
    chk("redir_instr", instr, 32'h1000_0010);

    // Pause: buffered word drains, fetch PC held.
    enable = 1'b0;
    cyc(3);
    chk("pause_valid", {31'b0, instr_valid}, 32'd0);
    chk("pause_addr", mem_addr, 32'h0040_0044);
    enable = 1'b1;

    // Run off the end of the ROM with bursty decode; buffered words drain.
    last_pc = '0;
    for (int i = 0; i < 300; i++) begin
      id_ready = (i % 3) != 0;
      @(negedge clk);
      if (instr_valid) last_pc = pc;
      if (fault && !instr_valid) break;
    end
    id_ready = 1'b1;
    chk("end_fault", {31'b0, fault}, 32'd1);
    chk("end_drained", {31'b0, instr_valid}, 32'd0);
    chk("end_last_pc", last_pc, 32'h0040_00FC);
    chk("end_addr", mem_addr, 32'h0040_0100);

    // Redirect out of FAULT.
    redirect = 1'b1; redirect_pc = 32'h0040_0000;
    cyc(1);
    redirect = 1'b0;
    chk("unfault", {31'b0, fault}, 32'd0);
    cyc(1);
    chk("restart_pc", pc, 32'h0040_0000);
    chk("restart_instr", instr, 32'h1000_0000);

    // Misaligned redirect target.
    redirect = 1'b1; redirect_pc = 32'h0040_0002;
    cyc(1);
    redirect = 1'b0;
    chk("mis_nofault_yet", {31'b0, fault}, 32'd0);
    cyc(1);
    chk("mis_fault", {31'b0, fault}, 32'd1);
    chk("mis_valid", {31'b0, instr_valid}, 32'd0);
    chk("mis_addr", mem_addr, 32'h0040_0002);

    // Mid-stream reset with a full buffer.
    redirect = 1'b1; redirect_pc = 32'h0040_0000; id_ready = 1'b0;
    cyc(1);
    redirect = 1'b0;
    cyc(3);
    chk("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
    chk("pre_rst_addr", mem_addr, 32'h0040_0008);
    reset = 1'b1; enable = 1'b0;
    cyc(1);
    reset = 1'b0;
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_addr", mem_addr, 32'h0040_0000);
    cyc(4);
    chk("idle_hold_valid", {31'b0, instr_valid}, 32'd0);
    chk("idle_hold_addr", mem_addr, 32'h0040_0000);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
